// File: rtl/flash_window_bridge.sv
`timescale 1ns/1ps
// Host ROM window onto a larger external flash, with a magic-read unlock sequence that switches
// between passthrough and a program mode (register file, flash reads, self-timed write pulses).
module flash_window_bridge #(
  parameter int unsigned HOST_AW  = 15,
  parameter int unsigned FLASH_AW = 19,
  parameter logic [11:0] KEY0     = 12'h555,
  parameter logic [11:0] KEY1     = 12'hAAA,
  parameter logic [11:0] KEY2     = 12'h555,
  parameter logic [11:0] KEY3     = 12'h2AA,
  parameter int unsigned WE_PULSE = 4
) (
  input  logic                fast_clock,
  input  logic                reset,
  input  logic [HOST_AW-1:0]  address,
  input  logic                _ce,
  input  logic                _oe,
  input  logic [7:0]          data_in,
  output logic [7:0]          data_out,
  output logic                data_oe,
  output logic                _ce_flash,
  output logic                _oe_flash,
  output logic                _we_flash,
  output logic [FLASH_AW-1:0] baddress,
  input  logic [7:0]          bdata_in,
  output logic [7:0]          bdata_out,
  output logic                bdata_oe,
  output logic                busy
);

  localparam int unsigned HI_W  = FLASH_AW - 16;
  localparam int unsigned CNT_W = $clog2(WE_PULSE + 1);

  typedef enum logic [2:0] {StLocked, StK1, StK2, StK3, StArmed} ulk_e;
  typedef enum logic [1:0] {WrIdle, WrSetup, WrPulse, WrHold} wr_e;

  logic unused_data_in;
  assign unused_data_in = ^data_in;

  logic        acc, ev, fall, decode, read_en;
  logic [2:0]  acc_sync_q;
  logic [2:0]  code;
  logic [11:0] akey;

  ulk_e                ulk_q, ulk_d;
  wr_e                 wr_q, wr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                prog_q, prog_d, pend_q, pend_d, pend_val_q, pend_val_d;
  logic [FLASH_AW-1:0] addr_q, addr_d;
  logic                autoinc_q, autoinc_d, overrun_q, overrun_d, rd6_q, rd6_d;
  logic [7:0]          status_q, status_d, wdata_q, wdata_d, rd_byte;

  assign acc  = ~_ce & ~_oe;
  assign ev   = acc_sync_q[1] & ~acc_sync_q[2];
  assign fall = ~acc_sync_q[1] & acc_sync_q[2];
  assign code = address[10:8];
  assign akey = address[11:0];
  assign busy = (wr_q != WrIdle);
  // The access that consumes the ARMED state only selects the mode; it is never a register op.
  assign decode = ev & prog_q & (ulk_q != StArmed);

  always_ff @(posedge fast_clock) begin
    if (reset) begin
      acc_sync_q <= '0;
      ulk_q      <= StLocked;
      wr_q       <= WrIdle;
      cnt_q      <= '0;
      prog_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= 1'b0;
      addr_q     <= '0;
      autoinc_q  <= 1'b0;
      overrun_q  <= 1'b0;
      rd6_q      <= 1'b0;
      status_q   <= '0;
      wdata_q    <= '0;
    end else begin
      acc_sync_q <= {acc_sync_q[1:0], acc};
      ulk_q      <= ulk_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      prog_q     <= prog_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      addr_q     <= addr_d;
      autoinc_q  <= autoinc_d;
      overrun_q  <= overrun_d;
      rd6_q      <= rd6_d;
      status_q   <= status_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    ulk_d      = ulk_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    prog_d     = prog_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    addr_d     = addr_q;
    autoinc_d  = autoinc_q;
    overrun_d  = overrun_q;
    rd6_d      = rd6_q;
    status_d   = status_q;
    wdata_d    = wdata_q;

    if (ev) begin
      case (ulk_q)
        StLocked: ulk_d = (akey == KEY0) ? StK1 : StLocked;
        StK1:     ulk_d = (akey == KEY1) ? StK2 : ((akey == KEY0) ? StK1 : StLocked);
        StK2:     ulk_d = (akey == KEY2) ? StK3 : ((akey == KEY0) ? StK1 : StLocked);
        StK3:     ulk_d = (akey == KEY3) ? StArmed : ((akey == KEY0) ? StK1 : StLocked);
        StArmed: begin
          ulk_d      = StLocked;
          pend_d     = 1'b1;
          pend_val_d = address[0];
        end
        default:  ulk_d = StLocked;
      endcase
    end

    // Mode switch lands once the host access is over and any write has drained.
    if (pend_q && !acc_sync_q[1] && !busy) begin
      prog_d = pend_val_q;
      pend_d = 1'b0;
    end

    case (wr_q)
      WrSetup: begin
        wr_d  = WrPulse;
        cnt_d = CNT_W'(WE_PULSE - 1);
      end
      WrPulse: begin
        if (cnt_q == '0) wr_d = WrHold;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      WrHold: begin
        wr_d = WrIdle;
        if (autoinc_q) addr_d = addr_q + FLASH_AW'(1);
      end
      default: ;
    endcase

    if (fall) begin
      rd6_d = 1'b0;
      if (rd6_q && autoinc_q) addr_d = addr_q + FLASH_AW'(1);
    end

    if (decode) begin
      if (code == 3'd3) begin
        status_d  = {busy, overrun_q, 4'b0, prog_q, autoinc_q};
        overrun_d = 1'b0;
      end else if (busy) begin
        if (code != 3'd5) overrun_d = 1'b1;
      end else begin
        case (code)
          3'd0: addr_d[7:0]           = address[7:0];
          3'd1: addr_d[15:8]          = address[7:0];
          3'd2: addr_d[FLASH_AW-1:16] = address[HI_W-1:0];
          3'd4: autoinc_d             = address[0];
          3'd6: rd6_d                 = 1'b1;
          3'd7: begin
            wr_d    = WrSetup;
            wdata_d = address[7:0];
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_byte = '0;
    case (code)
      3'd0: rd_byte            = addr_q[7:0];
      3'd1: rd_byte            = addr_q[15:8];
      3'd2: rd_byte[HI_W-1:0]  = addr_q[FLASH_AW-1:16];
      3'd3: rd_byte            = status_q;
      3'd4: rd_byte            = {7'b0, autoinc_q};
      3'd6: rd_byte            = bdata_in;
      default: rd_byte         = '0;
    endcase
  end

  assign read_en   = acc & (code == 3'd6) & ~busy;
  assign data_oe   = acc;
  assign data_out  = prog_q ? rd_byte : bdata_in;
  assign baddress  = prog_q ? addr_q : {addr_q[FLASH_AW-1:HOST_AW], address};
  assign _ce_flash = prog_q ? ~(read_en | busy) : ~acc;
  assign _oe_flash = prog_q ? ~read_en : ~acc;
  // Gated by reset so an interrupted write releases the flash in the reset cycle itself.
  assign _we_flash = ~((wr_q == WrPulse) & ~reset);
  assign bdata_oe  = busy & ~reset;
  assign bdata_out = wdata_q;

endmodule
